dram_dqs_wr_seq: RTL and testbench

Write-side DQS sequencer for one DRAM byte lane. It sits directly upstream of the DQS pad edge logic and turns accepted write-burst requests from the DRAM controller into the per-cycle `dram_io_drive_enable` / `dram_io_drive_data` pair that the edge logic flops and gates onto the pad. It generates the wait-for-write-latency interval, then a one-cycle preamble, the burst toggling cycles and a one-cycle postamble. It also handles back-to-back writes and channel disable.

---
 rtl/dram_dqs_pkg.sv | 24 ++
 rtl/dram_dqs_wr_seq.sv | 121 ++++++++++++
 tb/tb_dram_dqs_wr_seq.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/dram_dqs_pkg.sv
// -----------------------------------------------------------------------------
// dram_dqs_pkg
// Shared types and constants for the write-side DQS sequencer.
//   dqs_state_t   : sequencer phases (idle, write-latency wait, preamble,
//                   toggling burst, postamble)
//   DQS_BL4_CYC   : toggling cycles for a BL4 burst
//   DQS_BL8_CYC   : toggling cycles for a BL8 burst
//   DQS_LAT_W_DEF : default width of the write-latency field / down-counter
// -----------------------------------------------------------------------------
package dram_dqs_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_PRE   = 3'd2,
      S_BURST = 3'd3,
      S_POST  = 3'd4
   } dqs_state_t;

   localparam int DQS_BL4_CYC   = 2;
   localparam int DQS_BL8_CYC   = 4;
   localparam int DQS_LAT_W_DEF = 3;

endpackage : dram_dqs_pkg

// File: rtl/dram_dqs_wr_seq.sv
// -----------------------------------------------------------------------------
// dram_dqs_wr_seq
// Write-side DQS sequencer for one DRAM byte lane. Turns accepted write-burst
// requests into the per-cycle drive-enable / toggle-enable pair consumed by the
// DQS pad edge logic: write-latency wait, one-cycle preamble, BL4/BL8 toggling
// burst, one-cycle postamble. A new request may be accepted in the postamble
// cycle so back-to-back bursts keep the strobe driven without a gap.
//
// Ports:
//   clk                      : sole clock
//   rst                      : asynchronous, active-high reset
//   wr_req                   : write-burst request, qualified by wr_rdy
//   wr_latency [LAT_W-1:0]   : wait cycles between accept and preamble
//   wr_bl8                   : 0 = BL4 (2 toggling cycles), 1 = BL8 (4)
//   dram_io_channel_disabled : aborts and blocks all activity
//   wr_rdy                   : request can be accepted this cycle (comb.)
//   dram_io_drive_enable     : DQS output enable (preamble, burst, postamble)
//   dram_io_drive_data       : DQS toggle enable (burst only)
//   wr_done                  : high during the postamble cycle of each burst
// -----------------------------------------------------------------------------
module dram_dqs_wr_seq
   import dram_dqs_pkg::*;
#(
   parameter int LAT_W = DQS_LAT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_req,
   input  logic [LAT_W-1:0] wr_latency,
   input  logic             wr_bl8,
   input  logic             dram_io_channel_disabled,
   output logic             wr_rdy,
   output logic             dram_io_drive_enable,
   output logic             dram_io_drive_data,
   output logic             wr_done
);

   // Burst counter load values: the counter runs N-1 .. 0 across N cycles.
   localparam logic [LAT_W-1:0] BL4_LOAD = LAT_W'(DQS_BL4_CYC - 1);
   localparam logic [LAT_W-1:0] BL8_LOAD = LAT_W'(DQS_BL8_CYC - 1);

   dqs_state_t       state_q, state_d;
   logic [LAT_W-1:0] cnt_q,   cnt_d;
   logic             bl8_q,   bl8_d;
   logic             accept;

   // Ready only in IDLE or POST; POST acceptance is what allows gapless
   // back-to-back bursts.
   assign wr_rdy = ((state_q == S_IDLE) || (state_q == S_POST))
                   && !dram_io_channel_disabled;
   assign accept = wr_req && wr_rdy;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bl8_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bl8_q   <= bl8_d;
      end
   end

   // NOTE: every variable driven here gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bl8_d   = bl8_q;

      unique case (state_q)
         S_IDLE, S_POST: begin
            if (accept) begin
               bl8_d = wr_bl8;
               if (wr_latency != '0) begin
                  // Load L-1 so the WAIT phase lasts exactly L cycles.
                  state_d = S_WAIT;
                  cnt_d   = wr_latency - LAT_W'(1);
               end else begin
                  state_d = S_PRE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) state_d = S_PRE;
            else             cnt_d   = cnt_q - LAT_W'(1);
         end
         S_PRE: begin
            state_d = S_BURST;
            cnt_d   = bl8_q ? BL8_LOAD : BL4_LOAD;
         end
         S_BURST: begin
            if (cnt_q == '0) state_d = S_POST;
            else             cnt_d   = cnt_q - LAT_W'(1);
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Channel disable wins over everything, including a same-edge accept.
      if (dram_io_channel_disabled) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end
   end

   // Moore decode straight off the state register keeps the pad-side outputs
   // glitch-free and independent of the request inputs.
   assign dram_io_drive_enable = (state_q == S_PRE) || (state_q == S_BURST)
                                 || (state_q == S_POST);
   assign dram_io_drive_data   = (state_q == S_BURST);
   assign wr_done              = (state_q == S_POST);

endmodule : dram_dqs_wr_seq

// File: tb/tb_dram_dqs_wr_seq.sv
// -----------------------------------------------------------------------------
// tb_dram_dqs_wr_seq
// Directed bench for dram_dqs_wr_seq. Each burst request pushes its expected
// per-cycle output pattern {enable, data, done, rdy} onto a scoreboard queue;
// every clock step pops one entry and compares it with the DUT outputs sampled
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_dram_dqs_wr_seq;

   localparam int LAT_W = 3;

   typedef struct {
      string      tag;
      logic [3:0] v;     // {enable, data, done, rdy}
   } exp_t;

   logic             clk;
   logic             rst;
   logic             wr_req;
   logic [LAT_W-1:0] wr_latency;
   logic             wr_bl8;
   logic             dram_io_channel_disabled;
   logic             wr_rdy;
   logic             dram_io_drive_enable;
   logic             dram_io_drive_data;
   logic             wr_done;

   exp_t sb[$];
   int   checks;
   int   errors;
   int   en_cycles;

   dram_dqs_wr_seq #(.LAT_W(LAT_W)) dut (
      .clk                      (clk),
      .rst                      (rst),
      .wr_req                   (wr_req),
      .wr_latency               (wr_latency),
      .wr_bl8                   (wr_bl8),
      .dram_io_channel_disabled (dram_io_channel_disabled),
      .wr_rdy                   (wr_rdy),
      .dram_io_drive_enable     (dram_io_drive_enable),
      .dram_io_drive_data       (dram_io_drive_data),
      .wr_done                  (wr_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [3:0] observed();
      return {dram_io_drive_enable, dram_io_drive_data, wr_done, wr_rdy};
   endfunction

   function automatic void push(input string tag, input logic [3:0] v);
      exp_t e;
      e.tag = tag;
      e.v   = v;
      sb.push_back(e);
   endfunction

   // Expected cycles of one burst, starting with the cycle after the accept
   // edge: L x WAIT, PRE, N x BURST, POST (POST is ready for a new request).
   function automatic void push_burst(input int lat, input bit bl8);
      int n;
      n = bl8 ? 4 : 2;
      for (int i = 0; i < lat; i++) push($sformatf("wait%0d", i), 4'b0000);
      push("pre", 4'b1000);
      for (int i = 0; i < n; i++) push($sformatf("burst%0d", i), 4'b1100);
      push("post", 4'b1011);
   endfunction

   task automatic check_now(input string tag, input logic [3:0] exp_v);
      logic [3:0] obs;
      obs = observed();
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
      end
   endtask

   // Drive inputs for the current cycle, let one rising edge sample them,
   // then compare the resulting cycle against the scoreboard head.
   task automatic step(input logic req, input logic [LAT_W-1:0] lat,
                       input logic bl8, input logic dis);
      exp_t e;
      wr_req                   = req;
      wr_latency               = lat;
      wr_bl8                   = bl8;
      dram_io_channel_disabled = dis;
      @(posedge clk);
      @(negedge clk);
      if (dram_io_drive_enable) en_cycles++;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_underflow: observed %b expected none", observed());
      end else begin
         e = sb.pop_front();
         check_now(e.tag, e.v);
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      en_cycles = 0;

      // Reset with a request pulse that must be ignored.
      rst                      = 1'b1;
      wr_req                   = 1'b1;
      wr_latency               = 3'd0;
      wr_bl8                   = 1'b1;
      dram_io_channel_disabled = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check_now("reset_state", 4'b0001);
      rst    = 1'b0;
      wr_req = 1'b0;
      push("idle_after_reset", 4'b0001);
      step(1'b0, 3'd0, 1'b0, 1'b0);
      push("idle_after_reset2", 4'b0001);
      step(1'b0, 3'd0, 1'b0, 1'b0);

      // L=2, BL4: enable cycles 2-5, data 3-4, done 5, idle 6.
      push_burst(2, 1'b0);
      push("l2_idle", 4'b0001);
      step(1'b1, 3'd2, 1'b0, 1'b0);
      for (int i = 1; i <= 6; i++) step(1'b0, 3'd0, 1'b0, 1'b0);

      // L=0, BL8 twice, second accepted in POST: 12 gapless enable cycles.
      en_cycles = 0;
      push_burst(0, 1'b1);
      push_burst(0, 1'b1);
      push("b2b_idle", 4'b0001);
      step(1'b1, 3'd0, 1'b1, 1'b0);
      for (int i = 1; i <= 5; i++) step(1'b0, 3'd0, 1'b0, 1'b0);
      step(1'b1, 3'd0, 1'b1, 1'b0);
      for (int i = 7; i <= 12; i++) step(1'b0, 3'd0, 1'b0, 1'b0);
      checks++;
      assert (en_cycles === 12) else begin
         errors++;
         $error("FAIL b2b_enable_run: observed %0d expected %0d", en_cycles, 12);
      end

      // Request held through WAIT/BURST: only the POST cycle accepts it.
      push_burst(1, 1'b0);
      push_burst(1, 1'b0);
      push("held_idle", 4'b0001);
      for (int i = 0; i <= 5; i++) step(1'b1, 3'd1, 1'b0, 1'b0);
      for (int i = 6; i <= 10; i++) step(1'b0, 3'd0, 1'b0, 1'b0);

      // Disable pulsed in the second BURST cycle of a BL8, then a request
      // while disabled is rejected.
      push("dis_pre", 4'b1000);
      push("dis_burst0", 4'b1100);
      push("dis_burst1", 4'b1100);
      push("dis_abort", 4'b0000);
      push("dis_reject", 4'b0000);
      push("dis_release", 4'b0001);
      push("dis_idle", 4'b0001);
      step(1'b1, 3'd0, 1'b1, 1'b0);
      step(1'b0, 3'd0, 1'b0, 1'b0);
      step(1'b0, 3'd0, 1'b0, 1'b0);
      step(1'b0, 3'd0, 1'b0, 1'b1);
      step(1'b1, 3'd0, 1'b1, 1'b1);
      step(1'b0, 3'd0, 1'b0, 1'b0);
      step(1'b0, 3'd0, 1'b0, 1'b0);

      // Async reset mid-WAIT of an L=7 burst: IDLE without a clock edge.
      push_burst(7, 1'b0);
      step(1'b1, 3'd7, 1'b0, 1'b0);
      step(1'b0, 3'd0, 1'b0, 1'b0);
      step(1'b0, 3'd0, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check_now("async_rst", 4'b0001);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      check_now("rst_release", 4'b0001);

      // L=1 request completes normally after reset.
      push_burst(1, 1'b0);
      push("post_rst_idle", 4'b0001);
      step(1'b1, 3'd1, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) step(1'b0, 3'd0, 1'b0, 1'b0);

      checks++;
      assert (sb.size() === 0) else begin
         errors++;
         $error("FAIL scoreboard_drain: observed %0d entries expected %0d", sb.size(), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_dram_dqs_wr_seq
